// File: rtl/ingress_pkg.sv
// Shared definitions for the ingress loader: register map, status bits, FSM states.
// Imported by ingress_loader and ingress_port_ptr.
package ingress_pkg;

    localparam logic [4:0] ADDR_CNT_BASE = 5'd8;
    localparam logic [4:0] ADDR_STATUS   = 5'd16;
    localparam logic [4:0] ADDR_TIMER    = 5'd17;
    localparam logic [4:0] ADDR_CLEAR    = 5'd29;
    localparam logic [4:0] ADDR_RDEN     = 5'd30;
    localparam logic [4:0] ADDR_START    = 5'd31;

    localparam int ST_OVF_LSB  = 0;
    localparam int ST_BUSY     = 8;
    localparam int ST_BUSY_ERR = 9;
    localparam int ST_RDEN     = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/ingress_port_ptr.sv
// Per-port write pointer, fill count and sticky overflow flag for one port RAM.
// Ports: req (bus data write to this port), clr (global clear), wr_en/ptr to RAM,
// count (fill level, 0..2^DEPTH_LOG2), overflow (sticky drop flag).
module ingress_port_ptr
    import ingress_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  clr,
    output logic                  wr_en,
    output logic [DEPTH_LOG2-1:0] ptr,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam logic [DEPTH_LOG2+1:0] CAP =
        (DEPTH_LOG2 + 2)'(1) << DEPTH_LOG2;

    logic                  pend_q;
    logic [DEPTH_LOG2+1:0] used;
    logic                  full;
    logic                  accept;

    // A write accepted last cycle has not reached count yet, so it is
    // counted here to keep back-to-back writes from overfilling.
    assign used   = {1'b0, count} + {{(DEPTH_LOG2 + 1){1'b0}}, pend_q};
    assign full   = (used >= CAP);
    assign accept = req & ~full;

    // A clear in the same cycle cancels the RAM write.
    assign wr_en  = pend_q & ~clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= 1'b0;
            ptr      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            pend_q <= accept;
            if (clr) begin
                ptr      <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (pend_q) begin
                    count <= count + 1'b1;
                    if (ptr != '1)
                        ptr <= ptr + 1'b1;
                end
                if (req & full)
                    overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ingress_loader.sv
// Avalon-MM register front end that loads NPORTS external RAMs and starts a scheduler.
// Ports: clk, reset_n; chipselect/write/read/address/writedata/readdata (bus);
// wr_en/wr_addr/wr_data (RAMs); rd_enable, sched_start, sched_done, clr_pulse.
// Optional macro INGRESS_LOADER_TIMER_EN adds a 32-bit BUSY-cycle timer at address 17.
module ingress_loader
    import ingress_pkg::*;
#(
    parameter int NPORTS     = 4,
    parameter int DEPTH_LOG2 = 12,
    parameter int DW         = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         chipselect,
    input  logic                         write,
    input  logic                         read,
    input  logic [4:0]                   address,
    input  logic [DW-1:0]                writedata,
    output logic [DW-1:0]                readdata,
    output logic [NPORTS-1:0]            wr_en,
    output logic [NPORTS*DEPTH_LOG2-1:0] wr_addr,
    output logic [DW-1:0]                wr_data,
    output logic                         rd_enable,
    output logic                         sched_start,
    input  logic                         sched_done,
    output logic                         clr_pulse
);

    localparam logic [4:0] NP = 5'(NPORTS);

    state_t state_q;
    state_t state_d;
    logic   busy;
    logic   start_fire;

    logic bus_wr;
    logic bus_rd;
    logic port_wr;
    logic data_wr;
    logic drop_busy;
    logic clr_wr;
    logic rden_wr;
    logic start_wr;
    logic busy_err;

    logic [DEPTH_LOG2:0]   cnt [NPORTS];
    logic [DEPTH_LOG2-1:0] ptr [NPORTS];
    logic [NPORTS-1:0]     ovf;

    logic [31:0]   timer;
    logic [DW-1:0] status;
    logic [DW-1:0] rdata_d;

    assign bus_wr    = chipselect & write;
    assign bus_rd    = chipselect & read;
    assign port_wr   = bus_wr & (address < NP);
    assign data_wr   = port_wr & ~busy;
    assign drop_busy = port_wr & busy;
    assign clr_wr    = bus_wr & (address == ADDR_CLEAR);
    assign rden_wr   = bus_wr & (address == ADDR_RDEN);
    assign start_wr  = bus_wr & (address == ADDR_START);

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_wr)   state_d = BUSY;
            BUSY: if (sched_done) state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state_q == BUSY);
        start_fire = start_wr & (state_q == IDLE);
    end

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        ingress_port_ptr #(
            .DEPTH_LOG2(DEPTH_LOG2)
        ) u_ptr (
            .clk     (clk),
            .reset_n (reset_n),
            .req     (data_wr & (address[2:0] == 3'(k))),
            .clr     (clr_wr),
            .wr_en   (wr_en[k]),
            .ptr     (ptr[k]),
            .count   (cnt[k]),
            .overflow(ovf[k])
        );
        assign wr_addr[k*DEPTH_LOG2 +: DEPTH_LOG2] = ptr[k];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_data     <= '0;
            rd_enable   <= 1'b0;
            busy_err    <= 1'b0;
            clr_pulse   <= 1'b0;
            sched_start <= 1'b0;
            readdata    <= '0;
        end else begin
            clr_pulse   <= clr_wr;
            sched_start <= start_fire;
            readdata    <= rdata_d;
            if (data_wr)
                wr_data <= writedata;
            if (rden_wr)
                rd_enable <= writedata[0];
            if (clr_wr)
                busy_err <= 1'b0;
            else if (drop_busy)
                busy_err <= 1'b1;
        end
    end

`ifdef INGRESS_LOADER_TIMER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            timer <= '0;
        else if (start_fire)
            timer <= '0;
        else if (busy && timer != '1)
            timer <= timer + 1'b1;
    end
`else
    assign timer = '0;
`endif

    always_comb begin
        status = '0;
        status[ST_OVF_LSB +: NPORTS] = ovf;
        status[ST_BUSY]     = busy;
        status[ST_BUSY_ERR] = busy_err;
        status[ST_RDEN]     = rd_enable;
    end

    always_comb begin
        rdata_d = '0;
        if (bus_rd) begin
            unique case (1'b1)
                (address[4:3] == ADDR_CNT_BASE[4:3]): begin
                    for (int k = 0; k < NPORTS; k++)
                        if (address[2:0] == 3'(k))
                            rdata_d = DW'(cnt[k]);
                end
                (address == ADDR_STATUS): rdata_d = status;
                (address == ADDR_TIMER):  rdata_d = DW'(timer);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ingress_loader.sv
// Self-checking bench for ingress_loader (NPORTS=4, DEPTH_LOG2=2).
// Transaction-level model plus per-cycle compare and literal scenario checks.
module tb_ingress_loader;

    localparam int NP = 4;
    localparam int DL = 2;
    localparam int W  = 32;
    localparam int CAP = 1 << DL;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          chipselect = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [4:0]    address = '0;
    logic [W-1:0]  writedata = '0;
    logic          sched_done = 1'b0;
    logic [W-1:0]  readdata;
    logic [NP-1:0] wr_en;
    logic [NP*DL-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          rd_enable;
    logic          sched_start;
    logic          clr_pulse;

    always #5 clk = ~clk;

    ingress_loader #(
        .NPORTS(NP),
        .DEPTH_LOG2(DL),
        .DW(W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_enable  (rd_enable),
        .sched_start(sched_start),
        .sched_done (sched_done),
        .clr_pulse  (clr_pulse)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    // Model state
    int          m_cnt [NP];
    bit [NP-1:0] m_ovf;
    bit          m_busy, m_berr, m_rden;
    logic [31:0] m_timer;
    bit          m_pend;
    int          m_pport, m_paddr;
    logic [31:0] m_pdata;
    bit          m_clr_n, m_start_n;
    logic [31:0] m_rd_n;

    // Expected outputs for the current cycle
    bit          chk_on = 1'b0;
    logic [NP-1:0] e_wr_en;
    int          e_addr;
    logic [31:0] e_data, e_rdata;
    bit          e_clr, e_start, e_rden;

    int n_wr [NP];
    int n_start = 0;

    function automatic logic [31:0] model_read(input int a);
        if (a >= 8 && a < 8 + NP) return 32'(m_cnt[a-8]);
        if (a == 16) return {21'b0, m_rden, m_berr, m_busy, 4'b0, m_ovf};
`ifdef INGRESS_LOADER_TIMER_EN
        if (a == 17) return m_timer;
`endif
        return 32'd0;
    endfunction

    task automatic step(input bit rst, input bit c, input bit w, input bit r,
                        input logic [4:0] a, input logic [31:0] d,
                        input bit done);
        int  ai;
        bit  b0, is_clr;
        @(posedge clk);
        #1;
        reset_n = ~rst;
        chipselect = c; write = w; read = r;
        address = a; writedata = d; sched_done = done;
        chk_on = 1'b1;
        ai = int'(a);
        if (rst) begin
            e_wr_en = '0; e_addr = 0; e_data = '0; e_rdata = '0;
            e_clr = 0; e_start = 0; e_rden = 0;
            for (int k = 0; k < NP; k++) m_cnt[k] = 0;
            m_ovf = '0; m_busy = 0; m_berr = 0; m_rden = 0;
            m_timer = '0; m_pend = 0; m_clr_n = 0; m_start_n = 0;
            m_rd_n = '0;
            return;
        end
        is_clr = c & w & (ai == 29);
        e_wr_en = (m_pend && !is_clr) ? NP'(1 << m_pport) : '0;
        e_addr = m_paddr;
        e_data = m_pdata;
        e_clr = m_clr_n;
        e_start = m_start_n;
        e_rdata = m_rd_n;
        e_rden = m_rden;
        m_rd_n = (c & r) ? model_read(ai) : 32'd0;
        if (m_pend && !is_clr) m_cnt[m_pport]++;
        m_pend = 0; m_clr_n = 0; m_start_n = 0;
        b0 = m_busy;
        if (b0 && m_timer != 32'hFFFF_FFFF) m_timer++;
        if (b0 && done) m_busy = 0;
        if (c & w) begin
            if (ai < NP) begin
                if (b0) m_berr = 1;
                else if (m_cnt[ai] >= CAP) m_ovf[ai] = 1;
                else begin
                    m_pend = 1; m_pport = ai;
                    m_paddr = m_cnt[ai]; m_pdata = d;
                end
            end else if (ai == 29) begin
                for (int k = 0; k < NP; k++) m_cnt[k] = 0;
                m_ovf = '0; m_berr = 0; m_clr_n = 1;
            end else if (ai == 30) begin
                m_rden = d[0];
            end else if (ai == 31 && !b0) begin
                m_start_n = 1; m_busy = 1; m_timer = '0;
            end
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        step(0, 1, 1, 0, 5'(a), d, 0);
    endtask

    task automatic rd(input int a);
        step(0, 1, 0, 1, 5'(a), '0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic done_pulse();
        step(0, 0, 0, 0, '0, '0, 1);
    endtask

    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic rd_pin(input int a, input string nm, input logic [31:0] exp);
        rd(a);
        idle(1);
        @(negedge clk);
        check(nm, readdata, exp);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("wr_en", 32'(wr_en), 32'(e_wr_en));
            for (int k = 0; k < NP; k++)
                if (e_wr_en[k] && wr_en[k])
                    check($sformatf("wr_addr%0d", k),
                          32'(wr_addr[k*DL +: DL]), 32'(e_addr));
            if (e_wr_en != '0) check("wr_data", wr_data, e_data);
            check("clr_pulse", 32'(clr_pulse), 32'(e_clr));
            check("sched_start", 32'(sched_start), 32'(e_start));
            check("rd_enable", 32'(rd_enable), 32'(e_rden));
            check("readdata", readdata, e_rdata);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NP; k++)
            if (wr_en[k] === 1'b1) n_wr[k]++;
        if (sched_start === 1'b1) n_start++;
    end

    initial begin
        for (int k = 0; k < NP; k++) n_wr[k] = 0;

        rst_cycles(3);
        @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        idle(2);
        rd_pin(16, "status_after_reset", 32'd0);

        // Single write to port 2
        wr(2, 32'hA5A5_0001);
        idle(1);
        @(negedge clk);
        check("s1_wr_en", 32'(wr_en), 32'h4);
        check("s1_wr_addr", 32'(wr_addr[2*DL +: DL]), 32'd0);
        check("s1_wr_data", wr_data, 32'hA5A5_0001);
        rd_pin(10, "s1_cnt2", 32'd1);

        // Overfill port 0
        wr(29, 0);
        idle(1);
        n_wr[0] = 0;
        for (int i = 0; i < 5; i++) wr(0, 32'h100 + i);
        idle(2);
        check("s2_pulses", n_wr[0], 32'd4);
        rd_pin(16, "s2_status", 32'h1);
        rd_pin(8, "s2_cnt0", 32'd4);

        // Out-of-range and unmapped addresses
        n_wr[1] = 0;
        wr(5, 32'h55);
        idle(2);
        check("oor_no_write", 32'(wr_en), 32'd0);
        rd_pin(13, "oor_cnt", 32'd0);
        rd_pin(20, "unmapped", 32'd0);
        rd_pin(2, "data_addr_rd", 32'd0);

        // rd_enable
        wr(30, 1);
        idle(1);
        @(negedge clk);
        check("rden_level", 32'(rd_enable), 32'd1);
        rd_pin(16, "status_rden", 32'h401);

        // Start, write while busy, done
        wr(29, 0);
        idle(1);
        n_start = 0;
        n_wr[1] = 0;
        wr(31, 0);
        idle(2);
        wr(1, 32'hDEAD);
        wr(31, 0);
        idle(3);
        done_pulse();
        idle(2);
        done_pulse();
        idle(1);
        check("s3_starts", n_start, 32'd1);
        check("s3_no_port1", n_wr[1], 32'd0);
        rd_pin(16, "s3_status", 32'h600);

        // Clear in the wr_en cycle of a port 3 write
        wr(3, 32'h33);
        wr(29, 0);
        @(negedge clk);
        check("s4_wr_en", 32'(wr_en), 32'd0);
        idle(1);
        @(negedge clk);
        check("s4_clr_hi", 32'(clr_pulse), 32'd1);
        idle(1);
        @(negedge clk);
        check("s4_clr_lo", 32'(clr_pulse), 32'd0);
        rd_pin(11, "s4_cnt3", 32'd0);
        rd_pin(8, "s4_cnt0", 32'd0);

        // Timer over 100 busy cycles
        wr(31, 0);
        idle(99);
        done_pulse();
        idle(1);
`ifdef INGRESS_LOADER_TIMER_EN
        rd_pin(17, "s5_timer", 32'd100);
`else
        rd_pin(17, "s5_timer", 32'd0);
`endif

        // Reset in the middle of BUSY
        wr(29, 0);
        wr(0, 1);
        wr(1, 2);
        wr(2, 3);
        wr(31, 0);
        idle(3);
        rst_cycles(2);
        n_start = 0;
        idle(5);
        check("s6_no_start", n_start, 32'd0);
        for (int k = 0; k < NP; k++)
            rd_pin(8 + k, $sformatf("s6_cnt%0d", k), 32'd0);
        rd_pin(16, "s6_status", 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ingress_loader.md
INGRESS_LOADER -- requirements
Module: ingress_loader

Interface
REQ-001 SHALL have parameter NPORTS, default 4, meaning number of input ports/RAMs (legal 1..8).
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the words per port RAM.
REQ-003 SHALL have parameter DW, default 32, meaning data word width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have Avalon-MM slave inputs chipselect (1), write (1), read (1), address (5) and writedata (DW).
REQ-007 SHALL have output readdata, DW bits, with fixed read latency 1.
REQ-008 SHALL have outputs wr_en (NPORTS bits, one per port), wr_addr (NPORTS*DEPTH_LOG2 bits, port k at slice k) and wr_data (DW bits, shared), all to the external port RAMs.
REQ-009 SHALL have output rd_enable, 1 bit: level to the scheduler.
REQ-010 SHALL have output sched_start (1 bit, pulse), input sched_done (1 bit, pulse) and output clr_pulse (1 bit).

Function
REQ-011 SHALL decode the address map as follows:
- 0..7: data write to port k.
- 8..15: read fill count of port k-8.
- 16: status.
- 17: timer.
- 29: clear.
- 30: rd_enable (writedata[0]).
- 31: start.
REQ-012 SHALL ignore writes to data addresses k >= NPORTS, and reads of those addresses and of unmapped addresses SHALL return 0.
REQ-013 SHALL, on an accepted data write to port k, drive wr_en[k]=1 for exactly one cycle, starting one cycle after the bus write, with wr_data = the write data and wr_addr[k] = the pre-increment pointer.
REQ-014 SHALL increment the port k pointer and fill count by 1 in the wr_en cycle.
REQ-015 SHALL treat port k as full when its count = 2^DEPTH_LOG2; a data write to a full port is dropped, no wr_en is issued, and overflow[k] is set (sticky).
REQ-016 SHALL hold the pointer at its maximum when full and SHALL NOT wrap it.
REQ-017 SHALL, on a write to address 29, zero all pointers and counts and clear overflow and busy_err, with clr_pulse=1 for one cycle.
REQ-018 SHALL let the address-29 clear take precedence over a wr_en issued in the same cycle; that write is discarded.
REQ-019 SHALL, on a write to address 31 in IDLE, pulse sched_start for 1 cycle and go to BUSY; a write to address 31 in BUSY SHALL be ignored.
REQ-020 SHALL return from BUSY to IDLE on sched_done; sched_done in IDLE SHALL be ignored.
REQ-021 SHALL, in BUSY, drop data writes and set busy_err (sticky).
REQ-022 SHALL lay out the status register as: [7:0] overflow, [8] busy, [9] busy_err, [10] rd_enable, others 0.
REQ-023 SHALL return fill counts zero-extended to DW bits.
REQ-024 SHALL drive readdata to 0 in cycles with no read.

Reset
REQ-025 SHALL, while reset_n=0, set all of the following to 0: pointers, counts, flags, wr_en, wr_data, rd_enable, sched_start, clr_pulse, readdata, timer; the state SHALL be IDLE.
REQ-026 SHALL, on reset mid-BUSY, abandon the operation with no sched_start or clr_pulse emitted.

Configuration
REQ-027 SHALL provide macro INGRESS_LOADER_TIMER_EN; when it is defined, a 32-bit counter zeroes on start, increments each BUSY cycle, holds in IDLE, saturates at all-ones and is readable at address 17.
REQ-028 SHALL, when INGRESS_LOADER_TIMER_EN is undefined, omit the counter, and address 17 SHALL read 0.

Structure
REQ-029 SHALL place in package ingress_pkg the address constants, the status bit positions and the state enum (IDLE, BUSY).
REQ-030 SHALL implement each port's pointer, fill count and overflow logic in sub-module ingress_port_ptr, instantiated NPORTS times via generate.

Verification
REQ-031 SHALL be verified by writing 0xA5A5_0001 to address 2 -> one cycle later wr_en[2]=1, wr_addr[2]=0, wr_data=0xA5A5_0001; a read of address 10 then returns 1.
REQ-032 SHALL be verified with DEPTH_LOG2=2 by writing 5 words to port 0 -> exactly 4 wr_en pulses, with status[0]=1 and address 8 reading 4.
REQ-033 SHALL be verified by writing address 31, then address 1, then pulsing sched_done -> sched_start pulses once, the address-1 write is dropped, and status reads busy=0 and busy_err=1.
REQ-034 SHALL be verified by writing address 29 in the wr_en cycle of a port 3 write -> no RAM write, all counts 0, clr_pulse=1 for one cycle.
REQ-035 SHALL be verified, with INGRESS_LOADER_TIMER_EN defined, by start then sched_done after 100 cycles -> address 17 reads 100; without the macro it reads 0.
REQ-036 SHALL be verified by asserting reset_n=0 mid-BUSY after 3 writes -> all counts 0, status 0, no sched_start after release.
